alu_sequencer: RTL and testbench

Multi-cycle controller that sequences the 24-bit ALU datapath (array of 1-bit slices) for single-cycle logic/arithmetic ops, iterated 1-bit left shifts, and shift-add unsigned multiplication. It sits between the CPU control unit and the ALU. It owns the operand and accumulator registers and drives the ALU control lines (Op, BInvert, carry-in). Completion is reported to the control unit through a Start/Busy/Done handshake.

---
 rtl/alu_seq_pkg.sv | 54 +++++
 rtl/alu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the 24-bit ALU sequencer: command codes, ALU function
// selects, FSM states and the command-to-ALU decode helpers.
package alu_seq_pkg;

  localparam int         WIDTH     = 24;
  localparam logic [4:0] MUL_ITERS = 5'd24;

  typedef enum logic [2:0] {
    CMD_AND = 3'b000,
    CMD_OR  = 3'b001,
    CMD_ADD = 3'b010,
    CMD_SUB = 3'b011,
    CMD_SLT = 3'b100,
    CMD_XOR = 3'b101,
    CMD_SHL = 3'b110,
    CMD_MUL = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SLT  = 3'b011,
    ALU_ZERO = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SHL1 = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic alu_op_e cmd_to_alu_op(input cmd_e cmd);
    alu_op_e op;
    case (cmd)
      CMD_AND:                   op = ALU_AND;
      CMD_OR:                    op = ALU_OR;
      CMD_ADD, CMD_SUB, CMD_MUL: op = ALU_ADD;
      CMD_SLT:                   op = ALU_SLT;
      CMD_XOR:                   op = ALU_XOR;
      CMD_SHL:                   op = ALU_SHL1;
      default:                   op = ALU_AND;
    endcase
    return op;
  endfunction

  // SUB and SLT both compute A + ~B + 1 in the slice array.
  function automatic logic cmd_inverts_b(input cmd_e cmd);
    return (cmd == CMD_SUB) || (cmd == CMD_SLT);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the external 24-bit ALU: single-cycle ops, iterated
// SHL1 shifts and shift-add MUL. Define MUL_EARLY_EXIT_EN to end MUL once Q drains.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       Cmd,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [4:0]       ShAmt,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [2:0]       AluOp,
  output logic             AluBInvert,
  output logic             AluCin,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCarryOut,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Busy,
  output logic             Done
);

  state_e           state_r, state_nxt_s;
  cmd_e             cmd_r;
  logic [WIDTH-1:0] a_r, b_r, q_r, result_r;
  logic [WIDTH-1:0] acc_nxt_s, q_nxt_s;
  logic [4:0]       cnt_r;
  logic [2:0]       op_r;
  logic             binv_r, cin_r, carry_r, busy_r, done_r;
  logic             accept_s, last_s;

  // FSM state register
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode, command acceptance and end-of-run detection
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    q_nxt_s     = {1'b0, q_r[WIDTH-1:1]};
    if (q_r[0]) begin
      acc_nxt_s = AluResult;
    end else begin
      acc_nxt_s = a_r;
    end
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        case (cmd_r)
          CMD_SHL: last_s = (cnt_r <= 5'd1);
`ifdef MUL_EARLY_EXIT_EN
          CMD_MUL: last_s = (cnt_r == 5'd1) || (q_nxt_s == {WIDTH{1'b0}});
`else
          CMD_MUL: last_s = (cnt_r == 5'd1);
`endif
          default: last_s = 1'b1;
        endcase
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand, ALU drive and result registers; the A register doubles as Acc/shifter
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cmd_r    <= CMD_AND;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      cnt_r    <= 5'd0;
      op_r     <= 3'b000;
      binv_r   <= 1'b0;
      cin_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_RUN);
      done_r <= (state_nxt_s == ST_DONE);
      if (accept_s) begin
        cmd_r  <= cmd_e'(Cmd);
        q_r    <= OpB;
        op_r   <= cmd_to_alu_op(cmd_e'(Cmd));
        binv_r <= cmd_inverts_b(cmd_e'(Cmd));
        cin_r  <= cmd_inverts_b(cmd_e'(Cmd));
        case (cmd_e'(Cmd))
          CMD_MUL: begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= OpA;
            cnt_r <= MUL_ITERS;
          end
          CMD_SHL: begin
            a_r   <= OpA;
            b_r   <= {WIDTH{1'b0}};
            cnt_r <= ShAmt;
          end
          default: begin
            a_r   <= OpA;
            b_r   <= OpB;
            cnt_r <= 5'd1;
          end
        endcase
      end else if (state_r == ST_RUN) begin
        case (cmd_r)
          CMD_SHL: begin
            if (cnt_r != 5'd0) begin
              a_r   <= AluResult;
              cnt_r <= cnt_r - 5'd1;
            end
            if (last_s) begin
              result_r <= (cnt_r == 5'd0) ? a_r : AluResult;
              carry_r  <= 1'b0;
            end
          end
          CMD_MUL: begin
            a_r   <= acc_nxt_s;
            b_r   <= {b_r[WIDTH-2:0], 1'b0};
            q_r   <= q_nxt_s;
            cnt_r <= cnt_r - 5'd1;
            if (last_s) begin
              result_r <= acc_nxt_s;
              carry_r  <= 1'b0;
            end
          end
          default: begin
            result_r <= AluResult;
            carry_r  <= ((cmd_r == CMD_ADD) || (cmd_r == CMD_SUB)) ? AluCarryOut : 1'b0;
          end
        endcase
        // Park the ALU inputs at zero as soon as the run ends
        if (last_s) begin
          a_r    <= {WIDTH{1'b0}};
          b_r    <= {WIDTH{1'b0}};
          op_r   <= 3'b000;
          binv_r <= 1'b0;
          cin_r  <= 1'b0;
        end
      end
    end
  end

  assign AluA       = a_r;
  assign AluB       = b_r;
  assign AluOp      = op_r;
  assign AluBInvert = binv_r;
  assign AluCin     = cin_r;
  assign Result     = result_r;
  assign Carry      = carry_r;
  assign Busy       = busy_r;
  assign Done       = done_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural 24-bit ALU
// beside it; MUL latencies follow MUL_EARLY_EXIT_EN when that macro is defined.
module tb_alu_sequencer;

  localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_ADD = 3'b010, C_SUB = 3'b011;
  localparam logic [2:0] C_SLT = 3'b100, C_XOR = 3'b101, C_SHL = 3'b110, C_MUL = 3'b111;
`ifdef MUL_EARLY_EXIT_EN
  localparam int LAT_MUL_456 = 12, LAT_MUL_1000 = 14, LAT_MUL_0 = 2;
`else
  localparam int LAT_MUL_456 = 25, LAT_MUL_1000 = 25, LAT_MUL_0 = 25;
`endif

  logic        Clock = 1'b0, Reset_n = 1'b0, Start = 1'b0;
  logic [2:0]  Cmd = 3'b000;
  logic [23:0] OpA = 24'd0, OpB = 24'd0;
  logic [4:0]  ShAmt = 5'd0;
  logic [23:0] AluA, AluB, AluResult, Result;
  logic [2:0]  AluOp;
  logic        AluBInvert, AluCin, AluCarryOut, Carry, Busy, Done;
  logic [23:0] bb;
  logic [24:0] sum;
  int          n_tests = 0, n_fail = 0;

  alu_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Cmd(Cmd), .OpA(OpA), .OpB(OpB),
    .ShAmt(ShAmt), .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluBInvert(AluBInvert),
    .AluCin(AluCin), .AluResult(AluResult), .AluCarryOut(AluCarryOut), .Result(Result),
    .Carry(Carry), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Behavioural ALU as the parent would place it
  always_comb begin
    bb          = AluBInvert ? ~AluB : AluB;
    sum         = {1'b0, AluA} + {1'b0, bb} + {24'd0, AluCin};
    AluCarryOut = sum[24];
    case (AluOp)
      3'b000:  AluResult = AluA & bb;
      3'b001:  AluResult = AluA | bb;
      3'b010:  AluResult = sum[23:0];
      3'b011:  AluResult = {23'd0, sum[23]};
      3'b101:  AluResult = AluA ^ bb;
      3'b110:  AluResult = {AluA[22:0], 1'b0};
      default: AluResult = 24'd0;
    endcase
  end

  // Issue one command and report Done latency (-1 on timeout), result and handshake health
  task automatic run_cmd(input logic [2:0] c, input logic [23:0] a, input logic [23:0] b,
                         input logic [4:0] sh, output int lat, output logic [23:0] res,
                         output logic cy, output int busy_err, output logic done_after);
    @(negedge Clock);
    Start = 1'b1; Cmd = c; OpA = a; OpB = b; ShAmt = sh;
    @(posedge Clock);
    #1 Start = 1'b0;
    lat = -1; busy_err = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) begin
        lat = i;
        if (Busy !== 1'b0) busy_err++;
        break;
      end else if (Busy !== 1'b1) begin
        busy_err++;
      end
    end
    res = Result; cy = Carry;
    @(negedge Clock);
    done_after = Done;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_tests++;
    if ({Result, Carry, Busy, Done, AluA, AluB, AluOp, AluBInvert, AluCin} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got Result=%h Carry=%b Busy=%b Done=%b AluA=%h AluB=%h AluOp=%b, want all 0",
               Result, Carry, Busy, Done, AluA, AluB, AluOp);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    int done_seen = 0;
    int lat, be;
    logic [23:0] res;
    logic cy, da;
    @(negedge Clock);
    Start = 1'b1; Cmd = C_MUL; OpA = 24'h000123; OpB = 24'h000456;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) begin @(negedge Clock); if (Done === 1'b1) done_seen++; end
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    n_tests++;
    if ({Result, Carry, Busy, Done, AluA, AluB, AluOp, AluBInvert, AluCin} !== 80'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got Busy=%b AluA=%h AluB=%h AluOp=%b, want all 0", Busy, AluA, AluB, AluOp);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (30) begin @(negedge Clock); if (Done === 1'b1) done_seen++; end
    n_tests++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d Done pulses, want 0", done_seen);
    end
    run_cmd(C_AND, 24'hF0F0F0, 24'h0FF0FF, 5'd0, lat, res, cy, be, da);
    n_tests++;
    if (lat !== 2 || res !== 24'h00F0F0) begin
      n_fail++;
      $display("FAIL after_reset_and: got lat=%0d Result=%h, want lat=2 Result=00f0f0", lat, res);
    end
  endtask

  task automatic test_single_cycle();
    logic [2:0]  cmds [6] = '{C_SUB, C_SLT, C_OR, C_XOR, C_ADD, C_ADD};
    logic [23:0] as   [6] = '{24'h000005, 24'h000005, 24'hF0F0F0, 24'hF0F0F0, 24'hFFFFFF, 24'h123456};
    logic [23:0] bs   [6] = '{24'h000007, 24'h000007, 24'h0FF0FF, 24'h0FF0FF, 24'h000001, 24'h111111};
    logic [23:0] exp_r[6] = '{24'hFFFFFE, 24'h000001, 24'hFFF0FF, 24'hFF000F, 24'h000000, 24'h234567};
    logic        exp_c[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat, be;
    logic [23:0] res;
    logic cy, da;
    for (int i = 0; i < 6; i++) begin
      run_cmd(cmds[i], as[i], bs[i], 5'd0, lat, res, cy, be, da);
      n_tests++;
      if (res !== exp_r[i] || cy !== exp_c[i] || lat !== 2 || be !== 0 || da !== 1'b0) begin
        n_fail++;
        $display("FAIL single_cmd%0d: got Result=%h Carry=%b lat=%0d busy_err=%0d done_after=%b, want %h %b 2 0 0",
                 cmds[i], res, cy, lat, be, da, exp_r[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_shl();
    logic [23:0] as   [4] = '{24'h800001, 24'h800001, 24'hABCDEF, 24'hFFFFFF};
    logic [4:0]  sh   [4] = '{5'd3, 5'd0, 5'd24, 5'd31};
    logic [23:0] exp_r[4] = '{24'h000008, 24'h800001, 24'h000000, 24'h000000};
    int          exp_l[4] = '{4, 2, 25, 32};
    int lat, be;
    logic [23:0] res;
    logic cy, da;
    for (int i = 0; i < 4; i++) begin
      run_cmd(C_SHL, as[i], 24'h000000, sh[i], lat, res, cy, be, da);
      n_tests++;
      if (res !== exp_r[i] || lat !== exp_l[i] || cy !== 1'b0 || be !== 0) begin
        n_fail++;
        $display("FAIL shl_%0d: got Result=%h lat=%0d Carry=%b busy_err=%0d, want %h lat=%0d",
                 sh[i], res, lat, cy, be, exp_r[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [23:0] as   [4] = '{24'h000123, 24'h001000, 24'h00ABCD, 24'hFFFFFF};
    logic [23:0] bs   [4] = '{24'h000456, 24'h001000, 24'h000000, 24'hFFFFFF};
    logic [23:0] exp_r[4] = '{24'h04EDC2, 24'h000000, 24'h000000, 24'h000001};
    int          exp_l[4] = '{LAT_MUL_456, LAT_MUL_1000, LAT_MUL_0, 25};
    int lat, be;
    logic [23:0] res;
    logic cy, da;
    for (int i = 0; i < 4; i++) begin
      run_cmd(C_MUL, as[i], bs[i], 5'd0, lat, res, cy, be, da);
      n_tests++;
      if (res !== exp_r[i] || lat !== exp_l[i] || cy !== 1'b0 || be !== 0) begin
        n_fail++;
        $display("FAIL mul_%h_%h: got Result=%h lat=%0d Carry=%b busy_err=%0d, want %h lat=%0d",
                 as[i], bs[i], res, lat, cy, be, exp_r[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, bad_busy = 0;
    logic [23:0] r2 = 24'd0;
    @(negedge Clock);
    Start = 1'b1; Cmd = C_MUL; OpA = 24'h000123; OpB = 24'h000456;
    @(posedge Clock);
    for (int i = 1; i <= 80; i++) begin
      @(negedge Clock);
      if (Busy === Done) bad_busy++;
      if (Done === 1'b1) begin
        if (d1 < 0) begin
          d1 = i;
        end else begin
          d2 = i; r2 = Result; Start = 1'b0;
          break;
        end
      end
    end
    Start = 1'b0;
    n_tests++;
    if (d1 !== LAT_MUL_456 || d2 !== 2 * LAT_MUL_456) begin
      n_fail++;
      $display("FAIL b2b_timing: got Done at %0d and %0d, want %0d and %0d", d1, d2, LAT_MUL_456, 2 * LAT_MUL_456);
    end
    n_tests++;
    if (bad_busy !== 0 || r2 !== 24'h04EDC2) begin
      n_fail++;
      $display("FAIL b2b_busy_result: got bad_busy=%0d Result=%h, want 0 and 04edc2", bad_busy, r2);
    end
    repeat (2) @(negedge Clock);
    n_tests++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got Busy=%b Done=%b, want 0 0", Busy, Done);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_shl();
    test_mul();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
